// File: rtl/regfile_pkg.sv
// Shared widths and state encoding for the regfile bulk-transfer initiator.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } dma_state_t;

endpackage

// File: rtl/regfile_dma.sv
// Regfile bulk-transfer initiator: dumps a register run to a stream or loads a stream into registers.
// Optional REGFILE_DMA_CHECKSUM_EN adds a wrapping checksum of all handshaken words.
//
// state | meaning
// IDLE  | waiting for start; regfile ports released
// DUMP  | reading registers, presenting words on out_data/out_valid
// LOAD  | accepting in_data words and writing them into registers
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_dma
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rf_own,
    output logic [ADDR_W-1:0] rf_readnum,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [ADDR_W-1:0] rf_writenum,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_data_in
`ifdef REGFILE_DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W:0]   count_clamped;

`ifdef REGFILE_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    assign count_clamped = (count > NUM_REGS_W) ? NUM_REGS_W : count;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef REGFILE_DMA_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d = first_reg;
                    rem_d = count_clamped;
`ifdef REGFILE_DMA_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (count_clamped == '0)
                        state_d = DONE;
                    else
                        state_d = mode ? LOAD : DUMP;
                end
            end
            DUMP: begin
`ifdef REGFILE_DMA_CHECKSUM_EN
                if (out_valid_q && out_ready)
                    csum_d = csum_q + out_data_q;
`endif
                // The entry cycle (out_valid low) fetches; afterwards each handshake refetches.
                if (!out_valid_q || out_ready) begin
                    if (rem_q != '0) begin
                        out_data_d  = rf_data_out;
                        out_valid_d = 1'b1;
                        ptr_d       = ptr_q + ADDR_W'(1);
                        rem_d       = rem_q - (ADDR_W+1)'(1);
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - (ADDR_W+1)'(1);
`ifdef REGFILE_DMA_CHECKSUM_EN
                    csum_d = csum_q + in_data;
`endif
                    if (rem_q == (ADDR_W+1)'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef REGFILE_DMA_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef REGFILE_DMA_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Port-side outputs decode straight from the state flop so reset releases the regfile at once.
    assign busy        = (state_q == DUMP) || (state_q == LOAD);
    assign rf_own      = busy;
    assign done        = (state_q == DONE);
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign in_ready    = (state_q == LOAD);
    assign rf_write    = in_ready & in_valid;
    assign rf_writenum = in_ready ? ptr_q : '0;
    assign rf_data_in  = in_ready ? in_data : '0;
    assign rf_readnum  = (state_q == DUMP) ? ptr_q : '0;

`ifdef REGFILE_DMA_CHECKSUM_EN
    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_regfile_dma.sv
// Directed bench for regfile_dma with a behavioural 8x16 regfile beside it.
module tb_regfile_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  first_reg = '0;
    logic [3:0]  count = '0;
    logic        busy, done, out_valid, in_ready, rf_own, rf_write;
    logic [15:0] out_data, rf_data_out, rf_data_in;
    logic        out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  rf_readnum, rf_writenum;
`ifdef REGFILE_DMA_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic        preload = 1'b1;
    logic [15:0] rf [8];
    logic [15:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h1000 + 16'(i);
        end else if (rf_write) begin
            rf[rf_writenum] <= rf_data_in;
        end
    end

    assign rf_data_out = rf[rf_readnum];

    regfile_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .first_reg(first_reg), .count(count), .busy(busy), .done(done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rf_own(rf_own), .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
        .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in)
`ifdef REGFILE_DMA_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic m, input logic [2:0] f, input logic [3:0] c);
        @(posedge clk); #1;
        start = 1'b1; mode = m; first_reg = f; count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Follows a dump until done; every presented word must equal the next expected one.
    task automatic do_dump(input bit toggle, input string nm);
        int k = 0;
        int cyc = 0;
        int first_hs = -1;
        int last_hs = -1;
        int wr = 0;
        bit got_done = 0;
        while (cyc < 60) begin
            @(negedge clk);
            if (rf_write) wr++;
            if (out_valid) begin
                if (k < exp_q.size()) check({nm, "_data"}, 32'(out_data), 32'(exp_q[k]));
                else check({nm, "_extra_word"}, k, exp_q.size());
                if (out_ready) begin
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    k++;
                end
            end
            if (done) begin
                got_done = 1;
                break;
            end
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            cyc++;
        end
        check({nm, "_words"}, k, exp_q.size());
        check({nm, "_done"}, 32'(got_done), 1);
        check({nm, "_no_rf_write"}, wr, 0);
        if (!toggle) check({nm, "_consecutive"}, last_hs - first_hs + 1, exp_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] wd [3];
        bit          vpat [8];
        int          w;
        int          wr;
        bit          got_done;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_rf_own", 32'(rf_own), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        preload = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Full dump at full rate
        out_ready = 1'b1;
        exp_q = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007};
        kick(1'b0, 3'd0, 4'd8);
        check("t1_busy", 32'(busy), 1);
        check("t1_rf_own", 32'(rf_own), 1);
        do_dump(1'b0, "t1");
`ifdef REGFILE_DMA_CHECKSUM_EN
        check("t6_checksum", 32'(checksum), 32'h801C);
`endif

        // Wrapping dump with back-pressure, started right after the previous done
        out_ready = 1'b1;
        exp_q = '{16'h1006, 16'h1007, 16'h1000, 16'h1001};
        kick(1'b0, 3'd6, 4'd4);
        do_dump(1'b1, "t2");
        out_ready = 1'b1;

        // Load with gaps in in_valid
        wd   = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        vpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        w = 0; wr = 0; got_done = 0;
        kick(1'b1, 3'd2, 4'd3);
        check("t3_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            in_valid = vpat[i];
            in_data  = vpat[i] ? wd[w] : 16'hDEAD;
            @(negedge clk);
            if (rf_write) wr++;
            if (done) got_done = 1;
            if (in_valid) w++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t3_writes", wr, 3);
        check("t3_done", 32'(got_done), 1);
        for (int j = 0; j < 8; j++) begin
            if (j >= 2 && j <= 4) check("t3_reg", 32'(rf[j]), 32'(wd[j-2]));
            else check("t3_reg_kept", 32'(rf[j]), 32'h1000 + 32'(j));
        end

        // Zero-length transfer
        kick(1'b0, 3'd3, 4'd0);
        @(negedge clk);
        check("t4_zero_done", 32'(done), 1);
        check("t4_zero_out_valid", 32'(out_valid), 0);
        check("t4_zero_rf_write", 32'(rf_write), 0);
        check("t4_zero_busy", 32'(busy), 0);
        @(negedge clk);
        check("t4_done_pulse_width", 32'(done), 0);

        // Oversized count clamps to all registers
        exp_q = '{16'h1000, 16'h1001, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h1005, 16'h1006, 16'h1007};
        kick(1'b0, 3'd0, 4'd9);
        do_dump(1'b0, "t4_clamp");

        // Reset in the middle of a load
        kick(1'b1, 3'd5, 4'd3);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        @(posedge clk); #1;
        in_data  = 16'h6666;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rf_write", 32'(rf_write), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_in_ready", 32'(in_ready), 0);
        check("t5_rf_own", 32'(rf_own), 0);
        check("t5_writenum", 32'(rf_writenum), 0);
        got_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) got_done = 1;
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) got_done = 1;
        end
        check("t5_no_done", 32'(got_done), 0);
        check("t5_r5", 32'(rf[5]), 32'h5555);
        check("t5_r6", 32'(rf[6]), 32'h1006);
        check("t5_r4", 32'(rf[4]), 32'hCCCC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
